// File: rtl/tetris_board_renderer_if.sv
// tetris_board_renderer_if: game-logic access port to the playfield
// Signals:
//   wr_en/wr_col/wr_row/wr_data  cell write (ignored while busy or out of range)
//   rd_col/rd_row -> rd_data     registered cell read, 0 when busy or out of range
//   clear -> busy                start a board clear / clear in progress
// Modports: master = game logic, slave = board renderer.
interface tetris_board_renderer_if;
    logic       wr_en;
    logic [3:0] wr_col;
    logic [4:0] wr_row;
    logic [2:0] wr_data;
    logic [3:0] rd_col;
    logic [4:0] rd_row;
    logic [2:0] rd_data;
    logic       clear;
    logic       busy;
    modport master (output wr_en, wr_col, wr_row, wr_data, rd_col, rd_row, clear,
                    input  rd_data, busy);
    modport slave  (input  wr_en, wr_col, wr_row, wr_data, rd_col, rd_row, clear,
                    output rd_data, busy);
endinterface

// File: rtl/tetris_board_renderer.sv
// tetris_board_renderer: playfield store plus 2-stage pixel colour pipeline for the VGA driver
// Ports:
//   CLOCK_50  clock shared with the driver's x/y logic
//   reset     asynchronous active-low reset; starts a full board clear
//   x, y      pixel coordinate from the video driver
//   r, g, b   pixel colour, two cycles after x/y
//   bus       game-logic cell write/read and clear sequencer (slave side)
module tetris_board_renderer #(
    parameter int COLS      = 10,
    parameter int ROWS      = 20,
    parameter int CELL_LOG2 = 4,
    parameter int X0        = 240,
    parameter int Y0        = 80,
    parameter int BORDER_W  = 4
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic [9:0]                    x,
    input  logic [8:0]                    y,
    output logic [7:0]                    r,
    output logic [7:0]                    g,
    output logic [7:0]                    b,
    tetris_board_renderer_if.slave        bus
);
    localparam int N  = COLS * ROWS;
    localparam int AW = $clog2(N);
    localparam int BW = COLS << CELL_LOG2;
    localparam int BH = ROWS << CELL_LOG2;
    localparam logic [23:0] PAL [8] = '{24'h000000, 24'h00FFFF, 24'hFFFF00, 24'h8000FF,
                                        24'h00FF00, 24'hFF0000, 24'h0000FF, 24'hFF8000};

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            busy_q, busy_d;
    logic [2:0]      rd_q, rd_d;
    logic            in_board_q, in_board_d;
    logic            in_border_q, in_border_d;
    logic            grid_q, grid_d;
    logic [2:0]      vid_q, vid_d;
    logic [23:0]     rgb_q, rgb_d;

    logic [2:0]      mem [N];
    logic            we, rd_ok;
    logic [AW-1:0]   waddr, raddr, vaddr;
    logic [2:0]      wdata;
    logic [9:0]      dx, dy;
    int              xi, yi;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        if (state_q == CLEAR) begin
            addr_d = addr_q + AW'(1);
            if (addr_q == AW'(N - 1)) state_d = IDLE;
        end else if (bus.clear) begin
            state_d = CLEAR;
            addr_d  = '0;
        end
        busy_d = state_d == CLEAR;
    end

    // The clear sweep owns the single write port while busy.
    always_comb begin
        we    = busy_q || (bus.wr_en && int'(bus.wr_col) < COLS && int'(bus.wr_row) < ROWS);
        waddr = busy_q ? addr_q : AW'(int'(bus.wr_row) * COLS + int'(bus.wr_col));
        wdata = busy_q ? 3'd0 : bus.wr_data;
        rd_ok = int'(bus.rd_col) < COLS && int'(bus.rd_row) < ROWS;
        raddr = AW'(int'(bus.rd_row) * COLS + int'(bus.rd_col));
        rd_d  = (busy_q || !rd_ok) ? 3'd0 : mem[raddr];
    end

    // Stage 1: region flags and cell fetch; offsets wrap in 10 bits but only matter in_board.
    always_comb begin
        xi          = int'(x);
        yi          = int'(y);
        in_board_d  = xi >= X0 && xi < X0 + BW && yi >= Y0 && yi < Y0 + BH;
        in_border_d = !in_board_d && xi >= X0 - BORDER_W && xi < X0 + BW + BORDER_W &&
                      yi >= Y0 - BORDER_W && yi < Y0 + BH + BORDER_W;
        dx          = x - 10'(X0);
        dy          = {1'b0, y} - 10'(Y0);
        grid_d      = in_board_d && (dx[CELL_LOG2-1:0] == '0 || dy[CELL_LOG2-1:0] == '0);
        vaddr       = AW'(int'(dy >> CELL_LOG2) * COLS + int'(dx >> CELL_LOG2));
        vid_d       = in_board_d ? mem[vaddr] : 3'd0;
    end

    // Stage 2: colour select.
    always_comb begin
        rgb_d = in_board_q ? (vid_q != 3'd0 ? PAL[vid_q] : (grid_q ? 24'h202020 : 24'h000000))
                           : (in_border_q ? 24'h808080 : 24'h000000);
    end

    always_ff @(posedge CLOCK_50) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q     <= CLEAR;
            addr_q      <= '0;
            busy_q      <= 1'b1;
            rd_q        <= '0;
            in_board_q  <= 1'b0;
            in_border_q <= 1'b0;
            grid_q      <= 1'b0;
            vid_q       <= '0;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            rd_q        <= rd_d;
            in_board_q  <= in_board_d;
            in_border_q <= in_border_d;
            grid_q      <= grid_d;
            vid_q       <= vid_d;
            rgb_q       <= rgb_d;
        end
    end

    assign r           = rgb_q[23:16];
    assign g           = rgb_q[15:8];
    assign b           = rgb_q[7:0];
    assign bus.rd_data = rd_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_tetris_board_renderer.sv
// tb_tetris_board_renderer: scoreboard bench with a cell-array reference model
module tb_tetris_board_renderer;
    logic       clk, reset;
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] r, g, b;
    tetris_board_renderer_if bus();

    tetris_board_renderer dut (.CLOCK_50(clk), .reset(reset), .x(x), .y(y),
                               .r(r), .g(g), .b(b), .bus(bus));

    initial clk = 0;
    always #10 clk = ~clk;

    int          checks = 0, errors = 0;
    int          model [20][10];
    logic [23:0] vq [$];
    logic [2:0]  rq [$];
    logic        v_iss = 0, r_iss = 0, v_p1 = 0, v_p2 = 0, r_p1 = 0;
    logic        tb_busy = 0;
    int          hook_clr = -1, hook_wr = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] pal(int i);
        case (i)
            1: return 24'h00FFFF;
            2: return 24'hFFFF00;
            3: return 24'h8000FF;
            4: return 24'h00FF00;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            7: return 24'hFF8000;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] exp_pix(int xx, int yy);
        if (xx >= 240 && xx < 400 && yy >= 80 && yy < 400) begin
            int c = (xx - 240) / 16;
            int w = (yy - 80) / 16;
            if (model[w][c] != 0) return pal(model[w][c]);
            return ((xx - 240) % 16 == 0 || (yy - 80) % 16 == 0) ? 24'h202020 : 24'h000000;
        end
        if (xx >= 236 && xx < 404 && yy >= 76 && yy < 404) return 24'h808080;
        return 24'h000000;
    endfunction

    always @(posedge clk) begin
        v_p1 <= v_iss;
        v_p2 <= v_p1;
        r_p1 <= r_iss;
    end

    always @(negedge clk) begin
        logic [23:0] e;
        if (r_p1) begin
            if (rq.size() == 0) chk("rd_queue_underflow", 1, 0);
            else begin
                e = 24'(rq.pop_front());
                chk("rd_data", 32'(bus.rd_data), 32'(e));
            end
        end
        if (v_p2) begin
            if (vq.size() == 0) chk("rgb_queue_underflow", 1, 0);
            else begin
                e = vq.pop_front();
                chk("rgb", 32'({r, g, b}), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.wr_en = 0;
        bus.clear = 0;
        v_iss = 0;
        r_iss = 0;
    endtask

    task automatic px(input int xx, input int yy);
        x = 10'(xx);
        y = 9'(yy);
        vq.push_back(exp_pix(xx, yy));
        v_iss = 1;
    endtask

    task automatic rd(input int c, input int w);
        bus.rd_col = 4'(c);
        bus.rd_row = 5'(w);
        rq.push_back((c < 10 && w < 20) ? 3'(model[w][c]) : 3'd0);
        r_iss = 1;
    endtask

    task automatic wr(input int c, input int w, input int d);
        bus.wr_en   = 1;
        bus.wr_col  = 4'(c);
        bus.wr_row  = 5'(w);
        bus.wr_data = 3'(d);
        if (!tb_busy && c < 10 && w < 20) model[w][c] = d;
    endtask

    task automatic zero_model();
        foreach (model[i, j]) model[i][j] = 0;
    endtask

    task automatic read_all();
        for (int w = 0; w < 20; w++)
            for (int c = 0; c < 10; c++) begin
                rd(c, w);
                tick();
            end
    endtask

    // Counts busy cycles at negedges; returns at busy low, at stop_at, or at the 1000-cycle bound.
    task automatic busy_run(input int stop_at, output int n);
        bit done = 0;
        n = 0;
        while (!done) begin
            @(negedge clk);
            if (!bus.busy) done = 1;
            else begin
                n++;
                bus.clear = (n == hook_clr);
                bus.wr_en = 0;
                if (n == hook_wr) wr(1, 1, 3);
                done = (n == stop_at) || (n >= 1000);
            end
        end
        bus.clear = 0;
        bus.wr_en = 0;
    endtask

    initial begin
        int n;
        reset = 0;
        x = 10'd237;
        y = 9'd100;
        bus.wr_en = 0; bus.wr_col = 0; bus.wr_row = 0; bus.wr_data = 0;
        bus.rd_col = 0; bus.rd_row = 0; bus.clear = 0;
        zero_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rgb", 32'({r, g, b}), 0);
        chk("reset_rd_data", 32'(bus.rd_data), 0);
        chk("reset_busy", 32'(bus.busy), 1);
        @(posedge clk);
        #1 reset = 1;
        tb_busy = 1;
        busy_run(1000, n);
        chk("initial_clear_len", n, 200);
        tb_busy = 0;
        read_all();

        wr(3, 5, 2);
        tick();
        px(293, 165);
        rd(3, 5);
        tick();
        px(240, 100); tick();
        px(245, 85);  tick();
        px(237, 100); tick();
        px(10, 10);   tick();
        px(400, 100); tick();
        px(403, 403); tick();
        px(404, 100); tick();

        wr(10, 0, 5); tick();
        wr(0, 20, 5); tick();
        wr(15, 31, 5); tick();
        read_all();

        rd(0, 0);
        wr(0, 0, 7);
        tick();
        rd(0, 0);
        tick();

        wr(0, 0, 4);
        tick();
        bus.clear = 1;
        tb_busy = 1;
        tick();
        hook_clr = 50;
        hook_wr = 60;
        busy_run(1000, n);
        chk("reclear_len", n, 200);
        hook_clr = -1;
        hook_wr = -1;
        tb_busy = 0;
        zero_model();
        read_all();

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 3) == 0) px($urandom_range(0, 639), $urandom_range(0, 479));
                else px($urandom_range(220, 420), $urandom_range(60, 420));
            end
            if ($urandom_range(0, 1) == 1) rd($urandom_range(0, 11), $urandom_range(0, 21));
            if ($urandom_range(0, 2) == 0)
                wr($urandom_range(0, 11), $urandom_range(0, 21), $urandom_range(0, 7));
            tick();
        end
        read_all();
        repeat (3) tick();

        bus.clear = 1;
        tb_busy = 1;
        tick();
        busy_run(100, n);
        reset = 0;
        #1;
        chk("midclear_reset_busy", 32'(bus.busy), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midclear_reset_busy_hold", 32'(bus.busy), 1);
        chk("midclear_reset_rgb", 32'({r, g, b}), 0);
        @(posedge clk);
        #1 reset = 1;
        busy_run(1000, n);
        chk("restart_clear_len", n, 200);
        tb_busy = 0;
        zero_model();
        read_all();
        px(293, 165);
        tick();
        repeat (4) tick();
        chk("queues_drained", 32'(vq.size() + rq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
